// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download sequencer: FSM states, region indices
// and the one-hot region select encoding.
package rom_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [1:0] RGN_CPU  = 2'd0;
    localparam logic [1:0] RGN_SND  = 2'd1;
    localparam logic [1:0] RGN_GFX  = 2'd2;
    localparam logic [1:0] RGN_PROM = 2'd3;

    function automatic logic [3:0] rgn_sel(input logic [1:0] rgn);
        return 4'b0001 << rgn;
    endfunction

endpackage

// File: rtl/rom_region_dec.sv
// Combinational decode of an image byte address into region index,
// region-local address and an in-range flag.
module rom_region_dec
    import rom_dl_pkg::*;
#(
    parameter int CPU_SZ  = 16384,
    parameter int SND_SZ  = 4096,
    parameter int GFX_SZ  = 4096,
    parameter int PROM_SZ = 32
) (
    input  logic [24:0] addr,
    output logic [1:0]  rgn,
    output logic [15:0] local_addr,
    output logic        in_range
);

    localparam logic [24:0] BASE_SND  = 25'(CPU_SZ);
    localparam logic [24:0] BASE_GFX  = 25'(CPU_SZ + SND_SZ);
    localparam logic [24:0] BASE_PROM = 25'(CPU_SZ + SND_SZ + GFX_SZ);
    localparam logic [24:0] TOTAL     = 25'(CPU_SZ + SND_SZ + GFX_SZ + PROM_SZ);

    logic [24:0] base;

    // Ascending-base priority: a zero-size region has an empty interval and
    // can never win.
    always_comb begin
        rgn  = RGN_PROM;
        base = BASE_PROM;
        if (addr < BASE_SND) begin
            rgn  = RGN_CPU;
            base = '0;
        end else if (addr < BASE_GFX) begin
            rgn  = RGN_SND;
            base = BASE_SND;
        end else if (addr < BASE_PROM) begin
            rgn  = RGN_GFX;
            base = BASE_GFX;
        end
        local_addr = 16'(addr - base);
        in_range   = (addr < TOTAL);
    end

endmodule

// File: rtl/rom_dl_ctrl.sv
// Download sequencer: routes ioctl bytes into four ROM regions with a
// one-deep write buffer, holds the core in reset and grades the image.
module rom_dl_ctrl
    import rom_dl_pkg::*;
#(
    parameter int CPU_SZ   = 16384,
    parameter int SND_SZ   = 4096,
    parameter int GFX_SZ   = 4096,
    parameter int PROM_SZ  = 32,
    parameter int RST_HOLD = 256
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    input  logic        soft_reset,
    input  logic        mem_busy,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  dn_sel,
    output logic        core_reset,
    output logic        rom_ok,
    output logic        addr_err,
    output logic [2:0]  dbg_state
);

    localparam logic [16:0] TOTAL_CNT = 17'(CPU_SZ + SND_SZ + GFX_SZ + PROM_SZ);
    localparam logic [31:0] HOLD_INIT = 32'(RST_HOLD - 1);

    state_t      state, state_nx;
    logic [31:0] hold_cnt, hold_nx;
    logic [16:0] byte_cnt;
    logic        pending;
    logic        enter_load;
    logic [1:0]  rgn;
    logic [15:0] loc_addr;
    logic        in_range;
    logic        wr_seen, accept, drop, done;

    rom_region_dec #(
        .CPU_SZ (CPU_SZ),
        .SND_SZ (SND_SZ),
        .GFX_SZ (GFX_SZ),
        .PROM_SZ(PROM_SZ)
    ) u_dec (
        .addr      (ioctl_addr),
        .rgn       (rgn),
        .local_addr(loc_addr),
        .in_range  (in_range)
    );

    // Handshake: dn_wr/ioctl_wait mirror the one-deep buffer; a write
    // completes in any cycle with dn_wr=1 and mem_busy=0, and a strobe that
    // arrives while the buffer is full is dropped and flagged.
    assign wr_seen    = (state == ST_LOAD) && ioctl_wr;
    assign accept     = wr_seen && in_range && !pending;
    assign drop       = wr_seen && (!in_range || pending);
    assign done       = pending && !mem_busy;
    assign dn_wr      = pending;
    assign ioctl_wait = pending;
    assign dbg_state  = state;

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        case (state)
            ST_IDLE:  if (ioctl_download) state_nx = ST_LOAD;
            ST_LOAD:  if (!ioctl_download && !pending) state_nx = ST_CHECK;
            ST_CHECK: begin
                state_nx = ST_HOLD;
                hold_nx  = HOLD_INIT;
            end
            ST_HOLD: begin
                if (ioctl_download)      state_nx = ST_LOAD;
                else if (soft_reset)     hold_nx  = HOLD_INIT;
                else if (hold_cnt == '0) state_nx = ST_RUN;
                else                     hold_nx  = hold_cnt - 32'd1;
            end
            ST_RUN: begin
                if (ioctl_download) begin
                    state_nx = ST_LOAD;
                end else if (soft_reset) begin
                    state_nx = ST_HOLD;
                    hold_nx  = HOLD_INIT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        enter_load = (state_nx == ST_LOAD) && (state != ST_LOAD);
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
        end else begin
            state      <= state_nx;
            hold_cnt   <= hold_nx;
            core_reset <= (state_nx != ST_RUN);
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
            pending  <= 1'b0;
            dn_sel   <= '0;
            dn_addr  <= '0;
            dn_data  <= '0;
            rom_ok   <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            if (enter_load) begin
                byte_cnt <= '0;
                addr_err <= 1'b0;
                rom_ok   <= 1'b0;
            end else begin
                if (accept && byte_cnt != '1) byte_cnt <= byte_cnt + 17'd1;
                if (drop) addr_err <= 1'b1;
                if (state == ST_CHECK) rom_ok <= (byte_cnt == TOTAL_CNT) && !addr_err;
            end
            if (accept) begin
                pending <= 1'b1;
                dn_sel  <= rgn_sel(rgn);
                dn_addr <= loc_addr;
                dn_data <= ioctl_dout;
            end else if (done) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
